fetch_sequencer: RTL and testbench

- Control-step sequencer for the instruction-fetch phase (T0..T2) of the CPU.
- Produces the one-hot bus-source request vector `out_sel`, which feeds the 32-to-5 bus priority encoder (pe_32_5), plus the register-load/control strobes for each step.
- Waits on a memory-ready handshake during the read, with a bounded timeout.
- Guarantees at most one `out_sel` bit set; all-zero only when no step drives the bus.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control-step sequencer (T0..T2) with a bounded memory-ready wait.
// Drives the one-hot bus-source request vector for the 32-to-5 bus encoder plus per-step strobes.
//
// state | meaning
// IDLE  | waiting for start, all outputs quiet
// T0    | PCout, MARin, IncPC, Zin
// T1    | Zlowout, PCin, Read; MDRin if mem_ready
// MEMW  | Read held, waiting for mem_ready (bounded by MEM_TIMEOUT)
// T2    | MDRout, IRin
// DONE  | one-cycle done pulse
// ERR   | memory timeout, held until clear
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  output logic [31:0] out_sel,
  output logic        bus_en,
  output logic        MARin,
  output logic        Zin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        IRin,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [2:0]  step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_MEMW = 3'd3,
    S_T2   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd7
  } state_t;

  localparam int SEL_ZLOW = 19;
  localparam int SEL_PC   = 20;
  localparam int SEL_MDR  = 21;
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_T1)
        wait_cnt <= 8'd0;
      else if (state == S_MEMW && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = mem_ready ? S_T2 : S_MEMW;
      // ready wins over timeout when both land on the same cycle
      S_MEMW: begin
        if (mem_ready)
          state_nxt = S_T2;
        else if (wait_cnt == LAST_WAIT)
          state_nxt = S_ERR;
      end
      S_T2:   state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_sel     = 32'd0;
    MARin       = 1'b0;
    Zin         = 1'b0;
    IncPC       = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_T0: begin
        out_sel[SEL_PC] = 1'b1;
        MARin           = 1'b1;
        IncPC           = 1'b1;
        Zin             = 1'b1;
      end
      S_T1: begin
        out_sel[SEL_ZLOW] = 1'b1;
        PCin              = 1'b1;
        Read              = 1'b1;
        MDRin             = mem_ready;
      end
      S_MEMW: begin
        Read  = 1'b1;
        MDRin = mem_ready;
      end
      S_T2: begin
        out_sel[SEL_MDR] = 1'b1;
        IRin             = 1'b1;
      end
      S_DONE: done        = 1'b1;
      S_ERR:  timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign bus_en = |out_sel;
  assign step   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch paths, memory wait, timeout, clear and bus invariants.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] out_sel;
  logic        bus_en, MARin, Zin, IncPC, PCin, Read, MDRin, IRin;
  logic        busy, done, timeout_err;
  logic [2:0]  step;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.MEM_TIMEOUT(8)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready),
    .out_sel(out_sel), .bus_en(bus_en), .MARin(MARin), .Zin(Zin),
    .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin), .IRin(IRin),
    .busy(busy), .done(done), .timeout_err(timeout_err), .step(step)
  );

  always #5 clock = ~clock;

  // {bus_en, MARin, Zin, IncPC, PCin, Read, MDRin, IRin, busy, done, timeout_err}
  logic [10:0] ctl;
  assign ctl = {bus_en, MARin, Zin, IncPC, PCin, Read, MDRin, IRin, busy, done, timeout_err};

  localparam logic [10:0] C_IDLE   = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] C_T0     = 11'b1_1_1_1_0_0_0_0_1_0_0;
  localparam logic [10:0] C_T1     = 11'b1_0_0_0_1_1_0_0_1_0_0;
  localparam logic [10:0] C_T1_RDY = 11'b1_0_0_0_1_1_1_0_1_0_0;
  localparam logic [10:0] C_MW     = 11'b0_0_0_0_0_1_0_0_1_0_0;
  localparam logic [10:0] C_MW_RDY = 11'b0_0_0_0_0_1_1_0_1_0_0;
  localparam logic [10:0] C_T2     = 11'b1_0_0_0_0_0_0_1_1_0_0;
  localparam logic [10:0] C_DONE   = 11'b0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] C_ERR    = 11'b0_0_0_0_0_0_0_0_1_0_1;

  localparam logic [31:0] SEL_PC   = 32'h0010_0000;
  localparam logic [31:0] SEL_ZLOW = 32'h0008_0000;
  localparam logic [31:0] SEL_MDR  = 32'h0020_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_st(input string tag, input logic [2:0] st,
                        input logic [31:0] sel, input logic [10:0] c);
    chk({tag, " step"}, {29'd0, step}, {29'd0, st});
    chk({tag, " out_sel"}, out_sel, sel);
    chk({tag, " ctl"}, {21'd0, ctl}, {21'd0, c});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int enc_code(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b0;
    tick();
    clear = 1'b0;
    exp_st("reset", 3'd0, 32'd0, C_IDLE);

    // zero-wait fetch
    start = 1'b1; mem_ready = 1'b1;
    tick(); start = 1'b0;
    exp_st("zw t0", 3'd1, SEL_PC, C_T0);
    tick(); exp_st("zw t1", 3'd2, SEL_ZLOW, C_T1_RDY);
    tick(); exp_st("zw t2", 3'd4, SEL_MDR, C_T2);
    tick(); exp_st("zw done", 3'd5, 32'd0, C_DONE);
    tick(); exp_st("zw idle", 3'd0, 32'd0, C_IDLE);
    tick(); exp_st("zw stay idle", 3'd0, 32'd0, C_IDLE);

    // three wait cycles then ready
    start = 1'b1; mem_ready = 1'b0;
    tick(); start = 1'b0;
    exp_st("w3 t0", 3'd1, SEL_PC, C_T0);
    tick(); exp_st("w3 t1", 3'd2, SEL_ZLOW, C_T1);
    tick(); exp_st("w3 mw0", 3'd3, 32'd0, C_MW);
    tick(); exp_st("w3 mw1", 3'd3, 32'd0, C_MW);
    tick(); exp_st("w3 mw2", 3'd3, 32'd0, C_MW);
    tick(); exp_st("w3 mw3", 3'd3, 32'd0, C_MW);
    mem_ready = 1'b1; #1;
    exp_st("w3 mw3 rdy", 3'd3, 32'd0, C_MW_RDY);
    tick(); mem_ready = 1'b0; #1;
    exp_st("w3 t2", 3'd4, SEL_MDR, C_T2);
    tick(); exp_st("w3 done", 3'd5, 32'd0, C_DONE);
    tick(); exp_st("w3 idle", 3'd0, 32'd0, C_IDLE);

    // timeout: eight MEMW cycles then sticky ERR
    start = 1'b1;
    tick(); start = 1'b0;
    exp_st("to t0", 3'd1, SEL_PC, C_T0);
    tick(); exp_st("to t1", 3'd2, SEL_ZLOW, C_T1);
    for (int i = 0; i < 8; i++) begin
      tick(); exp_st($sformatf("to mw%0d", i), 3'd3, 32'd0, C_MW);
    end
    tick(); exp_st("to err", 3'd7, 32'd0, C_ERR);
    start = 1'b1; mem_ready = 1'b1;
    tick(); exp_st("to err start", 3'd7, 32'd0, C_ERR);
    start = 1'b0; mem_ready = 1'b0;
    tick(); exp_st("to err hold", 3'd7, 32'd0, C_ERR);
    clear = 1'b1;
    tick(); clear = 1'b0;
    exp_st("to clear", 3'd0, 32'd0, C_IDLE);

    // ready on the last allowed wait cycle
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); exp_st("last t1", 3'd2, SEL_ZLOW, C_T1);
    for (int i = 0; i < 8; i++) begin
      tick(); exp_st($sformatf("last mw%0d", i), 3'd3, 32'd0, C_MW);
    end
    mem_ready = 1'b1; #1;
    exp_st("last mw7 rdy", 3'd3, 32'd0, C_MW_RDY);
    tick(); mem_ready = 1'b0; #1;
    exp_st("last t2", 3'd4, SEL_MDR, C_T2);
    tick(); exp_st("last done", 3'd5, 32'd0, C_DONE);
    tick(); exp_st("last idle", 3'd0, 32'd0, C_IDLE);

    // clear during T1 (start held through T0 is ignored)
    start = 1'b1;
    tick(); exp_st("clr1 t0", 3'd1, SEL_PC, C_T0);
    start = 1'b0;
    tick(); exp_st("clr1 t1", 3'd2, SEL_ZLOW, C_T1);
    clear = 1'b1;
    tick(); clear = 1'b0;
    exp_st("clr1 idle", 3'd0, 32'd0, C_IDLE);

    // clear during MEMW
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    exp_st("clr2 mw1", 3'd3, 32'd0, C_MW);
    clear = 1'b1;
    tick(); clear = 1'b0;
    exp_st("clr2 idle", 3'd0, 32'd0, C_IDLE);
    tick(); exp_st("clr2 stay", 3'd0, 32'd0, C_IDLE);

    // start pulses while busy are not queued
    start = 1'b1; mem_ready = 1'b1;
    tick(); exp_st("nq t0", 3'd1, SEL_PC, C_T0);
    tick(); exp_st("nq t1", 3'd2, SEL_ZLOW, C_T1_RDY);
    tick(); exp_st("nq t2", 3'd4, SEL_MDR, C_T2);
    tick(); start = 1'b0;
    exp_st("nq done", 3'd5, 32'd0, C_DONE);
    tick(); exp_st("nq idle", 3'd0, 32'd0, C_IDLE);
    tick(); exp_st("nq stay", 3'd0, 32'd0, C_IDLE);

    // back-to-back: 5-cycle period
    start = 1'b1;
    tick(); exp_st("b2b t0a", 3'd1, SEL_PC, C_T0);
    tick(); tick(); tick();
    tick(); exp_st("b2b idle", 3'd0, 32'd0, C_IDLE);
    tick(); exp_st("b2b t0b", 3'd1, SEL_PC, C_T0);
    start = 1'b0;
    clear = 1'b1;
    tick(); clear = 1'b0;

    // random run: bus invariants and encoder code per step
    for (int i = 0; i < 300; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 40) == 0);
      #1;
      chk("rnd onehot", {31'd0, ($countones(out_sel) <= 1)}, 32'd1);
      chk("rnd bus_en", {31'd0, bus_en}, {31'd0, (out_sel != 32'd0)});
      case (step)
        3'd1: chk("rnd code t0", enc_code(out_sel), 20);
        3'd2: chk("rnd code t1", enc_code(out_sel), 19);
        3'd4: chk("rnd code t2", enc_code(out_sel), 21);
        default: ;
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
